// File: rtl/q2_sequencer.sv
// ============================================================================
// q2_sequencer
//   Q2 CPU state sequencer. Steps each instruction through FETCH (0),
//   optional DEREF (1), optional LOAD (2), EXEC (3) and the serial ALU states
//   (4 .. 3+ALU_BITS), then returns to FETCH. Each state spends one SETTLE
//   cycle (ws=0) and one STROBE cycle (ws=1). FETCH adds a DECODE cycle in
//   which the freshly loaded opcode bits are sampled.
//   Front-panel run/stop stops only at instruction boundaries.
//
//   Optional feature macro: Q2_SEQ_STEP_EN
//     defined   : step_sw rising edge while idle (go=0) runs one instruction
//     undefined : step_sw unused, only run_sw controls running
//
// Parameters
//   ALU_BITS     number of serial ALU states (1..12)
//   SYNC_STAGES  synchroniser depth for run_sw / step_sw (>=2)
//
// Ports
//   clk          in   system clock
//   rst_n        in   async active-low reset
//   run_sw       in   front-panel run switch (asynchronous level)
//   step_sw      in   front-panel step switch (asynchronous level)
//   deref        in   decoded opcode: indirect operand
//   o2           in   opcode bit 2
//   s2in         in   1 = enter ALU states after EXEC
//   s0..s3       out  binary state number, s0 = LSB (registered)
//   ws           out  write strobe (registered)
//   running      out  sequencer active
//   instr_done   out  one-cycle pulse when an instruction retires
//
// Handshake note: there is no valid/ready pair here; ws is a pure strobe that
// is high for exactly one cycle per state and only while running=1.
// ============================================================================
module q2_sequencer #(
    parameter int ALU_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_sw,
    input  logic step_sw,
    input  logic deref,
    input  logic o2,
    input  logic s2in,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic ws,
    output logic running,
    output logic instr_done
);

    localparam logic [3:0] LAST_STATE = 4'(3 + ALU_BITS);

    typedef enum logic [1:0] {
        PH_SETTLE = 2'd0,
        PH_STROBE = 2'd1,
        PH_DECODE = 2'd2
    } phase_t;

    logic [3:0]             s;
    phase_t                 phase;
    logic [SYNC_STAGES-1:0] run_sync;
    logic                   go;
    logic [3:0]             seq_next;
    logic [3:0]             decode_next;
    logic                   start;
    logic                   stop_at_boundary;

    assign go = run_sync[SYNC_STAGES-1];
    assign {s3, s2, s1, s0} = s;

`ifdef Q2_SEQ_STEP_EN
    logic [SYNC_STAGES-1:0] step_sync;
    logic                   step_prev;
    logic                   step_mode;
    logic                   step_rise;

    assign step_rise        = step_sync[SYNC_STAGES-1] & ~step_prev;
    // A step edge only matters when idle and not in run mode.
    assign start            = go | step_rise;
    assign stop_at_boundary = step_mode | ~go;
`else
    logic unused_step;
    assign unused_step      = step_sw;
    assign start            = go;
    assign stop_at_boundary = ~go;
`endif

    // Successor for every state except FETCH, which is steered in DECODE.
    // Out-of-range values fall back to FETCH so s never leaves 0..LAST_STATE.
    always_comb begin
        seq_next = 4'd0;
        case (s)
            4'd1:    seq_next = o2 ? 4'd3 : 4'd2;
            4'd2:    seq_next = 4'd3;
            4'd3:    seq_next = s2in ? 4'd4 : 4'd0;
            default: seq_next = (s >= LAST_STATE) ? 4'd0 : s + 4'd1;
        endcase
    end

    assign decode_next = deref ? 4'd1 : (o2 ? 4'd3 : 4'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s          <= 4'd0;
            phase      <= PH_SETTLE;
            ws         <= 1'b0;
            running    <= 1'b0;
            instr_done <= 1'b0;
            run_sync   <= '0;
`ifdef Q2_SEQ_STEP_EN
            step_sync  <= '0;
            step_prev  <= 1'b0;
            step_mode  <= 1'b0;
`endif
        end else begin
            run_sync   <= {run_sync[SYNC_STAGES-2:0], run_sw};
            instr_done <= 1'b0;
`ifdef Q2_SEQ_STEP_EN
            step_sync  <= {step_sync[SYNC_STAGES-2:0], step_sw};
            step_prev  <= step_sync[SYNC_STAGES-1];
`endif
            if (!running) begin
                // Idle: parked in FETCH SETTLE with the strobe off.
                s     <= 4'd0;
                phase <= PH_SETTLE;
                ws    <= 1'b0;
                if (start) begin
                    running <= 1'b1;
`ifdef Q2_SEQ_STEP_EN
                    step_mode <= ~go;
`endif
                end
            end else begin
                case (phase)
                    PH_SETTLE: begin
                        phase <= PH_STROBE;
                        ws    <= 1'b1;
                    end
                    PH_STROBE: begin
                        ws <= 1'b0;
                        if (s == 4'd0) begin
                            // Opcode register loads on this edge; decode next cycle.
                            phase <= PH_DECODE;
                        end else begin
                            phase <= PH_SETTLE;
                            s     <= seq_next;
                            if (seq_next == 4'd0) begin
                                instr_done <= 1'b1;
                                if (stop_at_boundary) begin
                                    running <= 1'b0;
`ifdef Q2_SEQ_STEP_EN
                                    step_mode <= 1'b0;
`endif
                                end
                            end
                        end
                    end
                    PH_DECODE: begin
                        phase <= PH_SETTLE;
                        s     <= decode_next;
                    end
                    default: begin
                        phase <= PH_SETTLE;
                        ws    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
